shift_register_universal: RTL and testbench
===========================================

# shift_register_universal

Parametrised universal shift register: the successor to the fixed 6-bit right-shift register in experiment 7. It adds width generalisation, left/right shift, optional rotate, and a counted burst-shift sequencer with a busy/done handshake. It sits between the lab switch/preset inputs and the LED/7-segment display logic, and drives both true and complemented outputs.

## Interface
- WIDTH, 6: register width in bits (≥2).
- COUNT_WIDTH, 3: width of the burst shift count.
- clockpulse  input  1  clock; all state changes on its rising edge.
- notclear  input  1  asynchronous, active-low reset.
- mode  input  3  000 hold, 001 shift right, 010 shift left, 011 rotate right, 100 rotate left; 101–111 hold.
- serialInput  input  1  bit entering out[WIDTH-1] on a right shift.
- serialInputLeft  input  1  bit entering out[0] on a left shift.
- enablePreset  input  1  synchronous parallel load of preset.
- preset  input  WIDTH  parallel load value.
- start  input  1  request a burst of count steps in the current mode.
- count  input  COUNT_WIDTH  number of burst steps.
- out  output  WIDTH  register contents.
- notout  output  WIDTH  always ~out.
- busy  output  1  high while the burst sequencer is in BUSY.
- done  output  1  one-cycle pulse when a burst completes.

## Operation
- Shift right: out <= {serialInput, out[WIDTH-1:1]}. Shift left: out <= {out[WIDTH-2:0], serialInputLeft}.
- Rotate right: out <= {out[0], out[WIDTH-1:1]}. Rotate left: out <= {out[WIDTH-2:0], out[WIDTH-1]}.
- Per-edge priority:
  1. enablePreset: out <= preset. In BUSY or DONE, this aborts to IDLE with no done pulse.
  2. BUSY: apply the captured mode.
  3. IDLE with start=0: apply the live mode.
- FSM states are IDLE, BUSY and DONE.
  - IDLE + start (enablePreset=0): capture mode and count, no shift this edge. If count≠0 go to BUSY, else go to DONE.
  - BUSY: one step per edge; the remaining count decrements; the edge applying the last step goes to DONE.
  - DONE: apply the live mode this edge (same as IDLE), then go to IDLE. start is ignored in DONE and BUSY.
- In BUSY, the live mode, serial inputs' mode selection, and start are ignored. serialInput and serialInputLeft are still sampled live.
- A burst with a hold or unused mode code still runs count cycles, leaving out unchanged.
- busy = (state==BUSY); done = (state==DONE).

## Timing
- notclear low, asynchronously: out=0, notout=all ones, busy=0, done=0, state IDLE, captured count and mode cleared.
- Deasserting notclear mid-burst leaves the block in IDLE; the burst is lost.
- Single-step latency: one edge from mode or enablePreset to out.
- Burst with start at edge k and count=N>0:
  - busy is high after edges k through k+N-1.
  - out changes at edges k+1 through k+N.
  - done is high for exactly one cycle after edge k+N.
- Burst with count=0: done is high after edge k; busy never rises.
- Back-to-back bursts: start is next accepted at the edge where the state is IDLE, which is two edges after the last step.
- Maximum burst length is 2^COUNT_WIDTH-1 steps.

## Configuration
- SHIFTREG_ROTATE_EN defined: mode codes 011 and 100 rotate as specified above.
- SHIFTREG_ROTATE_EN undefined: codes 011 and 100 behave as hold, in both direct and burst use, and no wrap-around path is synthesised.

## Test plan
- Reset and preset: notclear=0 → out=000000, notout=111111. Release, pulse enablePreset with preset=000011 → out=000011. Then 3 edges of mode=001, serialInput=0 → out=000001, 000000, 000000.
- Left shift: preset=000011, mode=010, serialInputLeft=1, 2 edges → out=001111.
- Rotate, SHIFTREG_ROTATE_EN defined: preset=000011, mode=011, 1 edge → out=100001. Build without the macro → out stays 000011.
- Burst: preset=000011, start with count=3 and mode=010, mode then changed to 000 → busy high for 3 cycles, out=011000, done high for 1 cycle, then IDLE.
- Boundaries:
  - count=0 → done pulse with busy never high.
  - start held high during BUSY → ignored.
  - enablePreset in the 2nd burst step with preset=101010 → out=101010, busy=0, no done.
- Async reset mid-burst: notclear pulsed low between edges during BUSY → out=0, busy=0 immediately, done never pulses.

Source files
------------

// File: rtl/shift_register_universal.sv
// ---------------------------------------------------------------------------
// shift_register_universal
//   Parametrised universal shift register with a counted burst sequencer.
//   Modes: 000 hold, 001 shift right, 010 shift left, 011 rotate right,
//   100 rotate left, 101-111 hold.
//   Optional feature macro: SHIFTREG_ROTATE_EN. When it is undefined, codes
//   011/100 hold and no wrap-around path exists.
//
// Parameters
//   WIDTH        register width (>= 2)
//   COUNT_WIDTH  width of the burst step count
// Ports
//   clockpulse       clock, rising edge
//   notclear         async active-low reset
//   mode[2:0]        operation code (live in IDLE/DONE, captured in BUSY)
//   serialInput      bit entering out[WIDTH-1] on a right shift
//   serialInputLeft  bit entering out[0] on a left shift
//   enablePreset     synchronous parallel load, highest priority, aborts burst
//   preset           parallel load value
//   start            request a burst of 'count' steps (accepted in IDLE only)
//   count            burst step count
//   out / notout     register contents and complement
//   busy / done      burst in progress / one-cycle completion pulse
// ---------------------------------------------------------------------------
module shift_register_universal #(
    parameter int WIDTH       = 6,
    parameter int COUNT_WIDTH = 3
) (
    input  logic                   clockpulse,
    input  logic                   notclear,
    input  logic [2:0]             mode,
    input  logic                   serialInput,
    input  logic                   serialInputLeft,
    input  logic                   enablePreset,
    input  logic [WIDTH-1:0]       preset,
    input  logic                   start,
    input  logic [COUNT_WIDTH-1:0] count,
    output logic [WIDTH-1:0]       out,
    output logic [WIDTH-1:0]       notout,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 state_q, state_n;
    logic [WIDTH-1:0]       data_q, data_n;
    logic [COUNT_WIDTH-1:0] cnt_q, cnt_n;
    logic [2:0]             cmode_q, cmode_n;

    // One register step for a given mode code.
    function automatic logic [WIDTH-1:0] step_fn(
        input logic [2:0]       m,
        input logic [WIDTH-1:0] v,
        input logic             sr,
        input logic             sl
    );
        logic [WIDTH-1:0] r;
        r = v;
        case (m)
            3'b001:  r = {sr, v[WIDTH-1:1]};
            3'b010:  r = {v[WIDTH-2:0], sl};
`ifdef SHIFTREG_ROTATE_EN
            3'b011:  r = {v[0], v[WIDTH-1:1]};
            3'b100:  r = {v[WIDTH-2:0], v[WIDTH-1]};
`endif
            default: r = v;
        endcase
        return r;
    endfunction

    always_comb begin
        state_n = state_q;
        data_n  = data_q;
        cnt_n   = cnt_q;
        cmode_n = cmode_q;
        if (enablePreset) begin
            // Parallel load wins and silently abandons any burst.
            data_n  = preset;
            state_n = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        // Capture edge: no shift happens here.
                        cmode_n = mode;
                        cnt_n   = count;
                        state_n = (count != '0) ? BUSY : DONE;
                    end else begin
                        data_n = step_fn(mode, data_q, serialInput, serialInputLeft);
                    end
                end
                BUSY: begin
                    data_n = step_fn(cmode_q, data_q, serialInput, serialInputLeft);
                    cnt_n  = cnt_q - COUNT_WIDTH'(1);
                    if (cnt_q == COUNT_WIDTH'(1))
                        state_n = DONE;
                end
                DONE: begin
                    // Behaves like IDLE without accepting start.
                    data_n  = step_fn(mode, data_q, serialInput, serialInputLeft);
                    state_n = IDLE;
                end
                default: state_n = IDLE;
            endcase
        end
    end

    always_ff @(posedge clockpulse or negedge notclear) begin
        if (!notclear) begin
            state_q <= IDLE;
            data_q  <= '0;
            cnt_q   <= '0;
            cmode_q <= '0;
        end else begin
            state_q <= state_n;
            data_q  <= data_n;
            cnt_q   <= cnt_n;
            cmode_q <= cmode_n;
        end
    end

    assign out    = data_q;
    assign notout = ~data_q;
    assign busy   = (state_q == BUSY);
    assign done   = (state_q == DONE);

endmodule

// File: tb/tb_shift_register_universal.sv
// ---------------------------------------------------------------------------
// Bench for shift_register_universal (WIDTH=6, COUNT_WIDTH=3). Directed
// scenarios followed by randomized cycles, each checked against a
// behavioural model (remaining-step counter + done flag, arithmetic shifts).
// ---------------------------------------------------------------------------
module tb_shift_register_universal;
    localparam int W  = 6;
    localparam int CW = 3;
    localparam int MASK = (1 << W) - 1;

    logic          clockpulse = 1'b0;
    logic          notclear = 1'b0;
    logic [2:0]    mode = 3'b000;
    logic          serialInput = 1'b0;
    logic          serialInputLeft = 1'b0;
    logic          enablePreset = 1'b0;
    logic [W-1:0]  preset = '0;
    logic          start = 1'b0;
    logic [CW-1:0] count = '0;
    logic [W-1:0]  out, notout;
    logic          busy, done;

    shift_register_universal #(.WIDTH(W), .COUNT_WIDTH(CW)) dut (
        .clockpulse(clockpulse), .notclear(notclear), .mode(mode),
        .serialInput(serialInput), .serialInputLeft(serialInputLeft),
        .enablePreset(enablePreset), .preset(preset), .start(start),
        .count(count), .out(out), .notout(notout), .busy(busy), .done(done)
    );

    always #5 clockpulse = ~clockpulse;

    int nvec = 0;
    int nerr = 0;

    // behavioural model
    int m_out = 0;
    int m_rem = 0;      // steps still to apply; >0 means a burst is running
    bit m_done = 0;
    int m_cmode = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        if (obs !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int apply_mode(input int m, input int v, input int sr, input int sl);
        case (m)
            1: return (v >> 1) + sr * (1 << (W - 1));
            2: return ((v * 2) + sl) & MASK;
`ifdef SHIFTREG_ROTATE_EN
            3: return (v >> 1) + (v % 2) * (1 << (W - 1));
            4: return ((v * 2) & MASK) + (v >> (W - 1));
`endif
            default: return v;
        endcase
    endfunction

    task automatic model_reset();
        m_out = 0; m_rem = 0; m_done = 0; m_cmode = 0;
    endtask

    task automatic model_edge();
        if (enablePreset) begin
            m_out = int'(preset); m_rem = 0; m_done = 0;
        end else if (m_rem > 0) begin
            m_out = apply_mode(m_cmode, m_out, int'(serialInput), int'(serialInputLeft));
            m_rem--;
            if (m_rem == 0) m_done = 1;
        end else if (m_done) begin
            m_out = apply_mode(int'(mode), m_out, int'(serialInput), int'(serialInputLeft));
            m_done = 0;
        end else if (start) begin
            m_cmode = int'(mode);
            if (count == 0) m_done = 1;
            else m_rem = int'(count);
        end else begin
            m_out = apply_mode(int'(mode), m_out, int'(serialInput), int'(serialInputLeft));
        end
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".out"},    32'(out),    32'(m_out));
        chk({tag, ".notout"}, 32'(notout), 32'((~m_out) & MASK));
        chk({tag, ".busy"},   32'(busy),   32'(m_rem > 0));
        chk({tag, ".done"},   32'(done),   32'(m_done));
    endtask

    // one rising edge: model follows the inputs held across it, then compare
    task automatic tick(input string tag);
        @(posedge clockpulse);
        model_edge();
        #1;
        check_model(tag);
    endtask

    task automatic do_preset(input logic [W-1:0] v);
        enablePreset = 1'b1; preset = v; start = 1'b0; mode = 3'b000;
        tick("preset");
        enablePreset = 1'b0;
    endtask

    initial begin
        // reset state
        #2;
        chk("rst.out", 32'(out), 32'h0);
        chk("rst.notout", 32'(notout), 32'h3f);
        chk("rst.busy", 32'(busy), 32'h0);
        chk("rst.done", 32'(done), 32'h0);
        model_reset();
        @(negedge clockpulse);
        notclear = 1'b1;

        // preset then shift right with zero fill
        do_preset(6'b000011);
        chk("tp.preset", 32'(out), 32'b000011);
        mode = 3'b001; serialInput = 1'b0;
        tick("sr1"); chk("tp.sr1", 32'(out), 32'b000001);
        tick("sr2"); chk("tp.sr2", 32'(out), 32'b000000);
        tick("sr3"); chk("tp.sr3", 32'(out), 32'b000000);

        // left shift with ones in
        do_preset(6'b000011);
        mode = 3'b010; serialInputLeft = 1'b1;
        tick("sl1"); tick("sl2");
        chk("tp.sl", 32'(out), 32'b001111);

        // rotate right
        do_preset(6'b000011);
        mode = 3'b011;
        tick("rr");
`ifdef SHIFTREG_ROTATE_EN
        chk("tp.rot", 32'(out), 32'b100001);
`else
        chk("tp.rot", 32'(out), 32'b000011);
`endif

        // burst of 3 left shifts; mode dropped to hold, start kept high
        do_preset(6'b000011);
        serialInputLeft = 1'b0;
        start = 1'b1; count = 3'd3; mode = 3'b010;
        tick("b.cap"); chk("tp.b.busy0", 32'(busy), 32'h1);
        mode = 3'b000;
        tick("b.s1"); tick("b.s2"); tick("b.s3");
        chk("tp.b.out", 32'(out), 32'b011000);
        chk("tp.b.done", 32'(done), 32'h1);
        start = 1'b0;
        tick("b.idle");
        chk("tp.b.done1", 32'(done), 32'h0);

        // count = 0
        start = 1'b1; count = 3'd0;
        tick("c0"); chk("tp.c0.done", 32'(done), 32'h1); chk("tp.c0.busy", 32'(busy), 32'h0);
        start = 1'b0;
        tick("c0.idle");

        // preset during the 2nd burst step aborts without done
        start = 1'b1; count = 3'd3; mode = 3'b010;
        tick("ab.cap"); start = 1'b0;
        tick("ab.s1");
        enablePreset = 1'b1; preset = 6'b101010;
        tick("ab.pre");
        chk("tp.ab.out", 32'(out), 32'b101010);
        chk("tp.ab.busy", 32'(busy), 32'h0);
        enablePreset = 1'b0; mode = 3'b000;
        tick("ab.after"); chk("tp.ab.done", 32'(done), 32'h0);

        // async reset during a burst
        start = 1'b1; count = 3'd5; mode = 3'b001;
        tick("ar.cap"); start = 1'b0;
        tick("ar.s1");
        #2 notclear = 1'b0;
        #1;
        model_reset();
        chk("ar.out", 32'(out), 32'h0);
        chk("ar.busy", 32'(busy), 32'h0);
        #1 notclear = 1'b1;
        for (int i = 0; i < 8; i++) tick("ar.post");

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            mode            = 3'($urandom_range(0, 7));
            serialInput     = 1'($urandom);
            serialInputLeft = 1'($urandom);
            enablePreset    = ($urandom_range(0, 15) == 0);
            preset          = W'($urandom);
            start           = ($urandom_range(0, 3) == 0);
            count           = CW'($urandom);
            tick("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
